// File: rtl/rv32_instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format codes,
// FSM states, immediate range limits and the beat/word bundles.
package rv32_instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_BAD = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OPIMM  = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int SHAMT_MAX = 31;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } word_t;

endpackage

// File: rtl/rv32_instr_encoder_if.sv
// Operand-beat input and {instr,addr} output streams of the encoder, both valid/ready.
interface rv32_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/rv32_enc_fifo.sv
// Small synchronous FIFO, D entries of W bits; push visible at the head one cycle later,
// push_ready low when full, simultaneous push/pop keeps occupancy.
module rv32_enc_fifo #(
  parameter int W = 64,
  parameter int D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [W-1:0]      push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [W-1:0]      pop_data,
  output logic [$clog2(D):0] occ
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0] FULL = (AW+1)'(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_fire;
  logic          pop_fire;

  assign push_ready = (cnt != FULL);
  assign pop_valid  = (cnt != '0);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign pop_data   = mem[rd_ptr];
  assign occ        = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Packs operand beats into RV32I words and streams them with IMEM addresses; 2-cycle
// beat-to-output latency, in_ready is a credit that never lets the output FIFO overflow.
module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int FIFO_D = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_W-1:0]     count,
  rv32_instr_encoder_if.slave  bus,
  output logic                 err,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int OCC_W = $clog2(FIFO_D) + 1;
  localparam logic [OCC_W:0] DEPTH = (OCC_W+1)'(FIFO_D);

  function automatic logic [31:0] encode(beat_t b);
    logic [31:0] w;
    w = '0;
    case (fmt_e'(b.fmt))
      FMT_R:   w = {b.funct7, b.rs2, b.rs1, b.funct3, b.rd, b.opcode};
      FMT_I:   w = {b.imm[11:0], b.rs1, b.funct3, b.rd, b.opcode};
      FMT_ISH: w = {b.funct7, b.imm[4:0], b.rs1, b.funct3, b.rd, b.opcode};
      FMT_S:   w = {b.imm[11:5], b.rs2, b.rs1, b.funct3, b.imm[4:0], b.opcode};
      FMT_B:   w = {b.imm[12], b.imm[10:5], b.rs2, b.rs1, b.funct3,
                    b.imm[4:1], b.imm[11], b.opcode};
      FMT_U:   w = {b.imm[31:12], b.rd, b.opcode};
      FMT_J:   w = {b.imm[20], b.imm[10:1], b.imm[11], b.imm[19:12], b.rd, b.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Immediate must round-trip exactly through the format's bit slots.
  function automatic logic imm_legal(beat_t b);
    logic signed [31:0] s;
    logic               ok;
    s  = $signed(b.imm);
    ok = 1'b0;
    case (fmt_e'(b.fmt))
      FMT_R:        ok = 1'b1;
      FMT_I, FMT_S: ok = (s >= IMM12_MIN) && (s <= IMM12_MAX);
      FMT_ISH:      ok = (b.imm <= 32'(SHAMT_MAX));
      FMT_B:        ok = (s >= IMMB_MIN) && (s <= IMMB_MAX) && !b.imm[0];
      FMT_U:        ok = (b.imm[11:0] == 12'h000);
      FMT_J:        ok = (s >= IMMJ_MIN) && (s <= IMMJ_MAX) && !b.imm[0];
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt_lat;
  logic [CNT_W-1:0] accepted;
  logic [31:0]      next_addr;
  logic             s1_valid;
  beat_t            s1_beat;
  beat_t            beat_in;
  logic             s1_legal;
  logic [31:0]      s1_word;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   inflight;
  logic             accept;
  logic             start_ok;
  logic             push_valid;
  logic             push_ready;
  logic             push_fire;
  word_t            push_word;
  word_t            head_word;

  assign beat_in = '{fmt:    bus.in_fmt,    opcode: bus.in_opcode,
                     rd:     bus.in_rd,     rs1:    bus.in_rs1,
                     rs2:    bus.in_rs2,    funct3: bus.in_funct3,
                     funct7: bus.in_funct7, imm:    bus.in_imm};

  assign inflight     = {1'b0, occ} + {{OCC_W{1'b0}}, s1_valid};
  assign bus.in_ready = (state == ST_RUN) && (accepted < cnt_lat) && (inflight < DEPTH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign s1_legal   = imm_legal(s1_beat);
  assign s1_word    = encode(s1_beat);
  assign push_valid = s1_valid && s1_legal;
  assign push_fire  = push_valid && push_ready;
  assign push_word  = '{addr: next_addr, instr: s1_word};

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (count != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if ((accepted == cnt_lat) && !s1_valid && (occ == '0)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lat   <= '0;
      accepted  <= '0;
      next_addr <= '0;
      s1_valid  <= 1'b0;
      s1_beat   <= '0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_beat <= beat_in;
      err <= s1_valid && !s1_legal;
      if (start_ok) begin
        cnt_lat   <= count;
        accepted  <= '0;
        next_addr <= base_addr;
        err_cnt   <= '0;
      end else begin
        if (accept)    accepted  <= accepted + CNT_W'(1);
        if (push_fire) next_addr <= next_addr + 32'd4;
        if (s1_valid && !s1_legal && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  rv32_enc_fifo #(
    .W (64),
    .D (FIFO_D)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_word),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (head_word),
    .occ        (occ)
  );

  assign bus.out_instr = head_word.instr;
  assign bus.out_addr  = head_word.addr;

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed and randomized bench for rv32_instr_encoder against a field-arithmetic model.
module tb_rv32_instr_encoder;
  import rv32_instr_encoder_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] count;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;
  logic             done;

  rv32_instr_encoder_if bus();

  rv32_instr_encoder #(.CNT_W(CNT_W), .FIFO_D(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .bus       (bus),
    .err       (err),
    .err_cnt   (err_cnt),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  int          rdy_mode = 0;
  logic [31:0] model_addr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int w);
    return (v >> lo) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = 32'(op) + 32'(f3) * 32'd4096 + 32'(rs1) * 32'd32768;
    case (fmt)
      FMT_R:   return base + 32'(rd) * 128 + 32'(rs2) * 32'h100000 + 32'(f7) * 32'h2000000;
      FMT_I:   return base + 32'(rd) * 128 + fld(imm, 0, 12) * 32'h100000;
      FMT_ISH: return base + 32'(rd) * 128 + fld(imm, 0, 5) * 32'h100000 + 32'(f7) * 32'h2000000;
      FMT_S:   return base + fld(imm, 0, 5) * 128 + 32'(rs2) * 32'h100000 + fld(imm, 5, 7) * 32'h2000000;
      FMT_B:   return base + fld(imm, 11, 1) * 128 + fld(imm, 1, 4) * 256 + 32'(rs2) * 32'h100000
                      + fld(imm, 5, 6) * 32'h2000000 + fld(imm, 12, 1) * 32'h80000000;
      FMT_U:   return 32'(op) + 32'(rd) * 128 + fld(imm, 12, 20) * 4096;
      FMT_J:   return 32'(op) + 32'(rd) * 128 + fld(imm, 12, 8) * 4096 + fld(imm, 11, 1) * 32'h100000
                      + fld(imm, 1, 10) * 32'h200000 + fld(imm, 20, 1) * 32'h80000000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] fmt, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (fmt)
      FMT_R:        return 1'b1;
      FMT_I, FMT_S: return (s >= -2048) && (s <= 2047);
      FMT_ISH:      return imm <= 32'd31;
      FMT_B:        return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      FMT_U:        return (imm % 4096) == 0;
      FMT_J:        return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    int bnd[12] = '{-2048, 2047, 2048, -2049, 31, 32, -4096, 4094, 4096, -1048576, 1048574, 1048576};
    case ($urandom % 6)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return 32'($urandom_range(0, 40));
      3:       return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      4:       return $urandom & 32'hFFFFF000;
      default: return 32'(bnd[$urandom % 12]);
    endcase
  endfunction

  // Output sink: pops are checked in order against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (err === 1'b1) err_seen++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          total++;
          assert (q.size() != 0) else begin
            bad++;
            $error("FAIL out_unexpected: observed instr=%h addr=%h expected none", bus.out_instr, bus.out_addr);
          end
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("out_instr", bus.out_instr, e.instr);
            check("out_addr", bus.out_addr, e.addr);
          end
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 3) != 0;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit use_w, input logic [31:0] w);
    int waited;
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_funct3 = f3; bus.in_funct7 = f7; bus.in_imm = imm; bus.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("in_accept_timeout", 32'(waited < 200), 32'd1);
    if (waited < 200) begin
      if (ref_legal(fmt, imm)) begin
        q.push_back('{model_addr, use_w ? w : ref_word(fmt, op, rd, rs1, rs2, f3, f7, imm)});
        model_addr += 32'd4;
      end else begin
        exp_err++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_random(input bit allow_bad);
    logic [2:0] fmt;
    fmt = 3'($urandom % 7);
    if (allow_bad && ($urandom % 10 == 0)) fmt = 3'd7;
    send(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
         7'($urandom), allow_bad ? rand_imm() : 32'd0, 1'b0, 32'd0);
  endtask

  task automatic start_batch(input logic [31:0] base, input logic [CNT_W-1:0] n);
    base_addr = base;
    count = n;
    start = 1'b1;
    model_addr = base;
    exp_err = 0;
    err_seen = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_batch();
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("queue_drained", 32'(q.size()), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(exp_err));
    check("err_pulses", 32'(err_seen), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold_instr;
    logic [31:0] hold_addr;
    int          rdy_seen;

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    bus.in_valid = 1'b0; bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_addr", bus.out_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // addi x1,x0,-1 with latency probe
    start_batch(32'h100, 1);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    @(negedge clk);
    check("latency_k", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_k1", 32'(bus.out_valid), 32'd1);
    finish_batch();

    // beq / jal / lui
    start_batch(32'h200, 3);
    send(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8, 1'b1, 32'hFE208CE3);
    send(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 32'h001000EF);
    send(FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7);
    finish_batch();

    // illegal I imm then sw x3,4(x2)
    start_batch(32'h400, 2);
    send(FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
    send(FMT_S, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd4, 1'b1, 32'h00312223);
    finish_batch();
    check("illegal_err_cnt_one", 32'(err_cnt), 32'd1);

    // backpressure: sink stalled, credit stops after two in flight
    rdy_mode = 2;
    @(posedge clk); #1;
    start_batch(32'h800, 5);
    send_random(1'b0);
    send_random(1'b0);
    @(negedge clk);
    hold_instr = bus.out_instr;
    hold_addr = bus.out_addr;
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) rdy_seen++;
    end
    check("bp_in_ready_low", 32'(rdy_seen), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_instr_stable", bus.out_instr, hold_instr);
    check("bp_addr_stable", bus.out_addr, hold_addr);
    @(posedge clk); #1;
    rdy_mode = 0;
    repeat (3) send_random(1'b0);
    finish_batch();

    // address wrap
    start_batch(32'hFFFFFFF8, 3);
    repeat (3) send_random(1'b0);
    finish_batch();

    // reset with a word sitting in the FIFO
    rdy_mode = 2;
    @(posedge clk); #1;
    start_batch(32'h1000, 2);
    send_random(1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;

    // zero-length batch
    start_batch(32'h0, 0);
    @(negedge clk);
    check("count0_done", 32'(done), 32'd1);
    check("count0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // randomized batches with random sink stalls and input gaps
    rdy_mode = 1;
    for (int b = 0; b < 5; b++) begin
      int n;
      n = 10 + int'($urandom % 20);
      start_batch($urandom & 32'hFFFFFFFC, CNT_W'(n));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom % 3) begin
          @(posedge clk); #1;
        end
        send_random(1'b1);
      end
      finish_batch();
    end
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
